alu_arbiter: RTL

Shares one `alu_onehot` datapath between two requesters in the pipelined RV32I core. Requester 0 is the execute stage and requester 1 is the address-generation / auxiliary path. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers operands into an issue stage, registers the ALU output into a result stage, and steers the response back to its owner with a tag and an illegal-opcode error flag. It also supports a flush of in-flight requester-0 work on branch redirect.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/util.sv | 16 +
 rtl/alu_onehot.sv | 31 +++
 rtl/rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 117 +++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Types and helpers shared by the two-requester ALU arbiter.
package alu_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int FUN_W   = util::ALU_W;

  typedef struct packed {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [FUN_W-1:0] fun;
  } alu_req_t;

  typedef struct packed {
    logic     valid;
    logic     owner;
    alu_req_t req;
  } issue_t;

  // Tags live beside the stage so their width can follow the block parameter.
  typedef struct packed {
    logic        valid;
    logic        owner;
    logic [31:0] result;
    logic        err;
  } stage_t;

  function automatic logic is_onehot(input logic [FUN_W-1:0] f);
    return (f != '0) && ((f & (f - FUN_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/util.sv
// Shared one-hot ALU function codes used by the core datapath.
package util;
  localparam int ALU_W = 11;

  localparam logic [ALU_W-1:0] ALU_ADD   = 11'b00000000001;
  localparam logic [ALU_W-1:0] ALU_SUB   = 11'b00000000010;
  localparam logic [ALU_W-1:0] ALU_SLL   = 11'b00000000100;
  localparam logic [ALU_W-1:0] ALU_SLT   = 11'b00000001000;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 11'b00000010000;
  localparam logic [ALU_W-1:0] ALU_XOR   = 11'b00000100000;
  localparam logic [ALU_W-1:0] ALU_SRL   = 11'b00001000000;
  localparam logic [ALU_W-1:0] ALU_SRA   = 11'b00010000000;
  localparam logic [ALU_W-1:0] ALU_OR    = 11'b00100000000;
  localparam logic [ALU_W-1:0] ALU_AND   = 11'b01000000000;
  localparam logic [ALU_W-1:0] ALU_COPY2 = 11'b10000000000;
endpackage

// File: rtl/alu_onehot.sv
// Combinational RV32I ALU selected by a one-hot function code.
module alu_onehot
  import util::*;
(
  input  logic [31:0]      i_op1,
  input  logic [31:0]      i_op2,
  input  logic [ALU_W-1:0] i_fun,
  output logic [31:0]      o_result
);
  logic [4:0] w_shamt;
  assign w_shamt = i_op2[4:0];

  // Function decode; non-one-hot codes fall to zero.
  always_comb begin
    o_result = 32'h0;
    case (i_fun)
      ALU_ADD:   o_result = i_op1 + i_op2;
      ALU_SUB:   o_result = i_op1 - i_op2;
      ALU_SLL:   o_result = i_op1 << w_shamt;
      ALU_SLT:   o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
      ALU_SLTU:  o_result = {31'd0, i_op1 < i_op2};
      ALU_XOR:   o_result = i_op1 ^ i_op2;
      ALU_SRL:   o_result = i_op1 >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_op1) >>> w_shamt);
      ALU_OR:    o_result = i_op1 | i_op2;
      ALU_AND:   o_result = i_op1 & i_op2;
      ALU_COPY2: o_result = i_op2;
      default:   o_result = 32'h0;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves only on an accepted grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);
  logic r_last;

  // Sole requester wins; on contention the one not granted last wins.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Reset to "last was 1" so requester 0 is favoured first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_adv) begin
      r_last <= o_gnt[1];
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters through an issue and a
// result stage, with requester-0 flush on branch redirect.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]      req_op1_i,
  input  logic [NUM_REQ-1:0][31:0]      req_op2_i,
  input  logic [NUM_REQ-1:0][FUN_W-1:0] req_fun_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag_i,
  input  logic                          flush_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  input  logic [NUM_REQ-1:0]            resp_ready_i,
  output logic [31:0]                   resp_result_o,
  output logic [TAG_W-1:0]              resp_tag_o,
  output logic                          resp_err_o
);
  issue_t             r_is;
  stage_t             r_rs;
  logic [TAG_W-1:0]   r_is_tag;
  logic [TAG_W-1:0]   r_rs_tag;

  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_sel;
  logic               w_hs;
  logic               w_resp_fire;
  logic               w_i_flush;
  logic               w_r_flush;
  logic               w_r_free;
  logic               w_i_to_r;
  logic               w_i_free;
  logic               w_legal;
  logic [31:0]        w_alu_res;
  alu_req_t           w_req_sel;

  // A flushed owner-0 entry frees its slot in the same cycle, keeping owner-1 work on time.
  assign w_i_flush   = flush_i & r_is.valid & ~r_is.owner;
  assign w_r_flush   = flush_i & r_rs.valid & ~r_rs.owner;
  assign w_resp_fire = |(resp_valid_o & resp_ready_i);
  assign w_r_free    = ~r_rs.valid | w_resp_fire | w_r_flush;
  assign w_i_to_r    = r_is.valid & ~w_i_flush & w_r_free;
  assign w_i_free    = ~r_is.valid | w_i_to_r | w_i_flush;

  assign w_arb_req   = req_valid_i & {1'b1, ~flush_i};
  assign req_ready_o = w_gnt & {NUM_REQ{w_i_free & rst_ni}};
  assign w_hs        = |req_ready_o;
  assign w_sel       = w_gnt[1];

  assign w_req_sel.op1 = req_op1_i[w_sel];
  assign w_req_sel.op2 = req_op2_i[w_sel];
  assign w_req_sel.fun = req_fun_i[w_sel];
  assign w_legal       = is_onehot(r_is.req.fun);

  rr_arb2 u_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_req   (w_arb_req),
    .i_adv   (w_hs),
    .o_gnt   (w_gnt)
  );

  alu_onehot u_alu (
    .i_op1    (r_is.req.op1),
    .i_op2    (r_is.req.op2),
    .i_fun    (r_is.req.fun),
    .o_result (w_alu_res)
  );

  // Response steering to the owner; requester 0 is masked during flush.
  always_comb begin
    resp_valid_o = '0;
    if (r_rs.valid && (r_rs.owner || !flush_i)) begin
      resp_valid_o[r_rs.owner] = 1'b1;
    end else begin
      resp_valid_o = '0;
    end
  end

  assign resp_result_o = r_rs.result;
  assign resp_tag_o    = r_rs_tag;
  assign resp_err_o    = r_rs.err;

  // Issue and result stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is     <= '0;
      r_is_tag <= '0;
      r_rs     <= '0;
      r_rs_tag <= '0;
    end else begin
      if (w_hs) begin
        r_is.valid <= 1'b1;
        r_is.owner <= w_sel;
        r_is.req   <= w_req_sel;
        r_is_tag   <= req_tag_i[w_sel];
      end else if (w_i_to_r || w_i_flush) begin
        r_is.valid <= 1'b0;
      end

      if (w_i_to_r) begin
        r_rs.valid  <= 1'b1;
        r_rs.owner  <= r_is.owner;
        r_rs.result <= w_legal ? w_alu_res : 32'h0;
        r_rs.err    <= ~w_legal;
        r_rs_tag    <= r_is_tag;
      end else if (w_resp_fire || w_r_flush) begin
        r_rs.valid <= 1'b0;
      end
    end
  end
endmodule
